// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator.
// Build option: CMP_EARLY_EXIT_EN stops the scan at the first differing digit.
package cmp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_SCAN = 2'd1;
  localparam state_t S_DONE = 2'd2;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } res_t;

  function automatic int ndig(input int w);
    return w / 2;
  endfunction

endpackage

// File: rtl/cmp_seq_ctrl_if.sv
// Request/response handshake bundle for cmp_seq_ctrl.
// master = requesting datapath, slave = controller.
interface cmp_seq_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             eq;
  logic             gt;
  logic             lt;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid,
    input  eq, gt, lt, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid,
    output eq, gt, lt, busy
  );

endinterface

// File: rtl/cmp2_slice.sv
// Combinational 2-bit unsigned compare slice.
// Shared by every digit of the scan.
module cmp2_slice
  import cmp_pkg::*;
(
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output res_t       o_res
);

  assign o_res.eq = (i_a == i_b);
  assign o_res.gt = (i_a >  i_b);
  assign o_res.lt = (i_a <  i_b);

endmodule

// File: rtl/cmp_seq_ctrl.sv
// MSB-first digit-serial magnitude compare controller.
// Build option: CMP_EARLY_EXIT_EN ends SCAN on the first differing digit.
module cmp_seq_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  cmp_seq_ctrl_if.slave bus
);

  localparam int NDIG = ndig(WIDTH);
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_bad_width
    $fatal(1, "cmp_seq_ctrl: WIDTH must be even and >= 2");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic             r_found;
  res_t             r_first;
  res_t             r_res;

  res_t             w_dig;
  res_t             w_fin;
  logic             w_hit;
  logic             w_last;
  logic [1:0]       w_da;
  logic [1:0]       w_db;

  assign w_da = r_a[{r_idx, 1'b0} +: 2];
  assign w_db = r_b[{r_idx, 1'b0} +: 2];

  cmp2_slice u_slice (
    .i_a   (w_da),
    .i_b   (w_db),
    .o_res (w_dig)
  );

  assign w_hit = !r_found && !w_dig.eq;
  // Before any difference, the current digit's verdict is the running verdict.
  assign w_fin = r_found ? r_first : w_dig;

`ifdef CMP_EARLY_EXIT_EN
  assign w_last = w_hit || r_found || (r_idx == '0);
`else
  assign w_last = (r_idx == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_found <= 1'b0;
      r_first <= '0;
      r_res   <= '0;
    end else begin
      unique case (1'b1)
        (r_state == S_IDLE): begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_idx   <= IW'(NDIG - 1);
            r_found <= 1'b0;
            r_first <= '0;
            r_state <= S_SCAN;
          end
        end
        (r_state == S_SCAN): begin
          if (w_hit) begin
            r_found <= 1'b1;
            r_first <= w_dig;
          end
          if (w_last) begin
            r_res   <= w_fin;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx - IW'(1);
          end
        end
        (r_state == S_DONE): begin
          if (bus.out_ready) begin
            r_res   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_res   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.eq        = r_res.eq;
  assign bus.gt        = r_res.gt;
  assign bus.lt        = r_res.lt;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Bench for cmp_seq_ctrl: directed cases plus random traffic
// against a transaction-level model.
module tb_cmp_seq_ctrl;

  localparam int W  = 8;
  localparam int ND = W / 2;
`ifdef CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;

  cmp_seq_ctrl_if #(.WIDTH(W)) bus ();

  cmp_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int digits_seen(input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    logic [W-1:0] sa;
    logic [W-1:0] sb;
    for (int d = ND - 1; d >= 0; d--) begin
      sa = a >> (2 * d);
      sb = b >> (2 * d);
      if (sa[1:0] != sb[1:0])
        return EARLY ? (ND - d) : ND;
    end
    return ND;
  endfunction

  function automatic logic [2:0] ref_res(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    if (a == b) return 3'b100;
    if (a > b)  return 3'b010;
    return 3'b001;
  endfunction

  // Transaction model: pending pair counts down its digits, then is held
  bit         m_pend = 1'b0;
  bit         m_have = 1'b0;
  int         m_left = 0;
  logic [2:0] m_res  = '0;
  int         n_acc  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0;
      m_have <= 1'b0;
      m_left <= 0;
      m_res  <= '0;
    end else if (m_have) begin
      if (bus.out_ready) m_have <= 1'b0;
    end else if (m_pend) begin
      if (m_left == 1) begin
        m_pend <= 1'b0;
        m_have <= 1'b1;
      end
      m_left <= m_left - 1;
    end else if (bus.in_valid) begin
      m_pend <= 1'b1;
      m_left <= digits_seen(bus.a, bus.b);
      m_res  <= ref_res(bus.a, bus.b);
      n_acc  <= n_acc + 1;
    end
  end

  logic [5:0] exp_v;
  logic [5:0] act_v;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_v = {!(m_pend || m_have), m_have,
               (m_have ? m_res : 3'b000), (m_pend || m_have)};
      act_v = {bus.in_ready, bus.out_valid,
               bus.eq, bus.gt, bus.lt, bus.busy};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t act=%b exp=%b",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_ovalid(input string nm, output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_pair(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] xres, input int xlat,
                          input string nm);
    int lat;
    bus.a = a;
    bus.b = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    wait_ovalid(nm, lat);
    chk({nm, "_lat"}, lat, xlat);
    chk({nm, "_flags"}, {bus.eq, bus.gt, bus.lt}, xres);
    chk({nm, "_model"}, m_res, xres);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({nm, "_drain"},
        {bus.in_ready, bus.out_valid, bus.eq, bus.gt, bus.lt},
        5'b10000);
  endtask

  task automatic backpressure();
    int lat;
    int acc0;
    logic [2:0] snap;
    bus.a = 8'h12;
    bus.b = 8'h13;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_ovalid("bp", lat);
    snap = {bus.eq, bus.gt, bus.lt};
    chk("bp_flags", snap, 3'b001);
    acc0 = n_acc;
    bus.a = 8'h7F;
    bus.b = 8'h80;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold",
          {bus.in_ready, bus.out_valid, bus.eq, bus.gt, bus.lt},
          {2'b01, snap});
    end
    chk("bp_no_accept", n_acc, acc0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_release", {bus.in_ready, bus.out_valid}, 2'b10);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_accept", {bus.busy, bus.in_ready}, 2'b10);
    wait_ovalid("bp2", lat);
    chk("bp2_flags", {bus.eq, bus.gt, bus.lt}, 3'b001);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic reset_mid_scan();
    bit seen;
    bus.a = 8'h00;
    bus.b = 8'hFF;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_scan_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_abort", {bus.busy, bus.in_ready, bus.out_valid}, 3'b010);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("rst_no_result", seen, 1'b0);
    bus.out_ready = 1'b0;
  endtask

  task automatic random_traffic(input int ncyc);
    logic [W-1:0] ra;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      ra = W'($urandom);
      bus.a = ra;
      case ($urandom_range(0, 3))
        0:       bus.b = ra;
        1:       bus.b = ra ^ W'(1 << $urandom_range(0, W - 1));
        default: bus.b = W'($urandom);
      endcase
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (ND + 4) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state",
        {bus.in_ready, bus.out_valid, bus.eq, bus.gt, bus.lt, bus.busy},
        6'b100000);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    run_pair(8'hA5, 8'hA5, 3'b100, ND, "eq_a5");
    run_pair(8'hC0, 8'h40, 3'b010, EARLY ? 1 : ND, "gt_c0");
    run_pair(8'h12, 8'h13, 3'b001, ND, "lt_12");
    run_pair(8'h31, 8'h13, 3'b010, EARLY ? 2 : ND, "gt_31");
    run_pair(8'h00, 8'h00, 3'b100, ND, "eq_00");
    run_pair(8'hFF, 8'hFE, 3'b010, ND, "gt_ff");
    backpressure();
    reset_mid_scan();
    random_traffic(1500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
